// File: rtl/dtc_window_accumulator_if.sv
// Handshake bundle for dtc_window_accumulator.
//   in_valid/in_ready/in_pred/in_label : prediction beat (upstream -> stage)
//   out_valid/out_ready/out_pos/out_match/out_major : window result (stage -> consumer)
// Modports: master = upstream/consumer side, slave = the accumulator.
interface dtc_window_accumulator_if #(
  parameter int WINDOW = 16
) ();
  localparam int CW = $clog2(WINDOW + 1);

  logic          in_valid;
  logic          in_ready;
  logic          in_pred;
  logic          in_label;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_pos;
  logic [CW-1:0] out_match;
  logic          out_major;

  modport master (
    output in_valid, in_pred, in_label, out_ready,
    input  in_ready, out_valid, out_pos, out_match, out_major
  );

  modport slave (
    input  in_valid, in_pred, in_label, out_ready,
    output in_ready, out_valid, out_pos, out_match, out_major
  );
endinterface

// File: rtl/dtc_window_accumulator.sv
// Window accumulator for the decision-tree classifier's 1-bit prediction.
// Counts positive predictions (and prediction/label agreements) over WINDOW
// samples and emits one result beat per window with a majority vote.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear of the in-progress window
//   bus  : dtc_window_accumulator_if.slave (prediction in, result out)
// Build option: DTC_ACC_LABEL_EN builds the label/match path; without it
// in_label is ignored and out_match is constant 0.
module dtc_window_accumulator #(
  parameter  int WINDOW = 16,
  localparam int CW     = $clog2(WINDOW + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  dtc_window_accumulator_if.slave       bus
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pos_acc_q, pos_acc_d;
  logic [CW-1:0] pos_q;
  logic          major_q;
  logic          out_valid_q, out_valid_d;

  logic          last;
  logic          accept;
  logic          load;
  logic          pop;
  logic [CW-1:0] pos_sum;
  logic [CW:0]   pos_x2;
  logic          major_sum;

  assign last    = (cnt_q == CW'(WINDOW - 1));
  assign pop     = out_valid_q && bus.out_ready;
  // Only the window-completing sample stalls while a result is still pending.
  assign bus.in_ready = !(out_valid_q && !bus.out_ready && last);
  assign accept  = bus.in_valid && bus.in_ready;
  // A beat taken on a clr edge is dropped, so it can never complete a window.
  assign load    = accept && last && !clr;

  // Final total fits in CW bits because CW covers WINDOW.
  assign pos_sum   = pos_acc_q + CW'(bus.in_pred);
  assign pos_x2    = {pos_sum, 1'b0};
  assign major_sum = (pos_x2 > (CW+1)'(WINDOW));

  always_comb begin
    cnt_d       = cnt_q;
    pos_acc_d   = pos_acc_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      cnt_d     = '0;
      pos_acc_d = '0;
    end else if (accept) begin
      if (last) begin
        cnt_d     = '0;
        pos_acc_d = '0;
      end else begin
        cnt_d     = cnt_q + 1'b1;
        pos_acc_d = pos_sum;
      end
    end
    // New result wins over a same-edge pop, keeping out_valid high.
    if (load)     out_valid_d = 1'b1;
    else if (pop) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      pos_acc_q   <= '0;
      pos_q       <= '0;
      major_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pos_acc_q   <= pos_acc_d;
      out_valid_q <= out_valid_d;
      if (load) begin
        pos_q   <= pos_sum;
        major_q <= major_sum;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_pos   = pos_q;
  assign bus.out_major = major_q;

`ifdef DTC_ACC_LABEL_EN
  logic [CW-1:0] match_acc_q, match_q;
  logic [CW-1:0] match_sum;

  assign match_sum = match_acc_q + CW'(bus.in_pred == bus.in_label);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_acc_q <= '0;
      match_q     <= '0;
    end else begin
      if (clr)                   match_acc_q <= '0;
      else if (accept && last)   match_acc_q <= '0;
      else if (accept)           match_acc_q <= match_sum;
      if (load)                  match_q     <= match_sum;
    end
  end

  assign bus.out_match = match_q;
`else
  assign bus.out_match = '0;
  wire unused_label = bus.in_label;
`endif

endmodule
